// File: rtl/lane_game_pixel_gen.sv
// Pixel generator and per-frame game state for the lane-dodging aeroplane game.
// Draws scrolling lane dividers, the player plane and one falling obstacle.
module lane_game_pixel_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_LANES   = 3,
  parameter int LANE_W      = 213,
  parameter int DIV_W       = 50,
  parameter int DASH_LEN    = 70,
  parameter int DASH_GAP    = 50,
  parameter int SCROLL_STEP = 2,
  parameter int PLANE_Y     = 380,
  parameter int OBS_SIZE    = 40,
  parameter int OBS_SPEED   = 4
) (
  input  logic       clk_d,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       restart,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int PERIOD  = DASH_LEN + DASH_GAP;
  localparam int PLANE_H = 70;

  localparam logic [11:0] H_ACTIVE_C  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACTIVE_C  = 12'(V_ACTIVE);
  localparam logic [11:0] LANE_W_C    = 12'(LANE_W);
  localparam logic [11:0] HALF_LANE_C = 12'(LANE_W / 2);
  localparam logic [11:0] DIV_HALF_C  = 12'(DIV_W / 2);
  localparam logic [11:0] DASH_LEN_C  = 12'(DASH_LEN);
  localparam logic [11:0] PERIOD_C    = 12'(PERIOD);
  localparam logic [11:0] STEP_C      = 12'(SCROLL_STEP);
  localparam logic [11:0] PLANE_Y_C   = 12'(PLANE_Y);
  localparam logic [11:0] PLANE_H_C   = 12'(PLANE_H);
  localparam logic [11:0] OBS_SIZE_C  = 12'(OBS_SIZE);
  localparam logic [11:0] OBS_HALF_C  = 12'(OBS_SIZE / 2);
  localparam logic [11:0] OBS_SPEED_C = 12'(OBS_SPEED);
  localparam logic [2:0]  LANE_MAX    = 3'(NUM_LANES - 1);
  localparam logic [2:0]  LANE_MID    = 3'(NUM_LANES / 2);
  localparam logic [7:0]  LANE_CNT_C  = 8'(NUM_LANES);

  logic [2:0] player_lane_q, player_lane_d;
  logic [2:0] obs_lane_q, obs_lane_d;
  logic [9:0] obs_y_q, obs_y_d;
  logic [9:0] scroll_q, scroll_d;
  logic [7:0] score_q, score_d;
  logic       game_over_q, game_over_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       left_pend_q, left_pend_d;
  logic       right_pend_q, right_pend_d;
  logic       restart_pend_q, restart_pend_d;
  logic [3:0] red_q, red_d;
  logic [3:0] green_q, green_d;
  logic [3:0] blue_q, blue_d;

  logic frame_tick;
  assign frame_tick = (pixel_x == 10'd0) && ({2'b00, pixel_y} == V_ACTIVE_C);

  // True when p lies in the half-open span [c - half, c + half), without underflow.
  function automatic logic in_span(input logic [11:0] p, input logic [11:0] c,
                                   input logic [11:0] half);
    return ((p + half) >= c) && (p < (c + half));
  endfunction

  logic [11:0] px, py, player_cx, obs_cx, obs_top, dash_phase;
  logic        plane_px, obs_px, divider_px, dash_px;

  always_comb begin
    px         = {2'b00, pixel_x};
    py         = {2'b00, pixel_y};
    player_cx  = 12'(player_lane_q) * LANE_W_C + HALF_LANE_C;
    obs_cx     = 12'(obs_lane_q) * LANE_W_C + HALF_LANE_C;
    obs_top    = {2'b00, obs_y_q};
    plane_px   = (in_span(px, player_cx, 12'd15) &&
                  (py >= PLANE_Y_C) && (py < PLANE_Y_C + PLANE_H_C)) ||
                 (in_span(px, player_cx, 12'd30) &&
                  (py >= PLANE_Y_C + 12'd20) && (py < PLANE_Y_C + 12'd50));
    obs_px     = in_span(px, obs_cx, OBS_HALF_C) &&
                 (py >= obs_top) && (py < obs_top + OBS_SIZE_C);
    divider_px = 1'b0;
    for (int k = 1; k < NUM_LANES; k++) begin
      if (in_span(px, 12'(k * LANE_W), DIV_HALF_C)) divider_px = 1'b1;
    end
    // Subtracting the scroll offset makes the dash pattern slide downwards.
    dash_phase = (py + PERIOD_C - {2'b00, scroll_q}) % PERIOD_C;
    dash_px    = divider_px && (dash_phase < DASH_LEN_C) && (px < H_ACTIVE_C);
  end

  always_comb begin
    red_d   = 4'h0;
    green_d = 4'h0;
    blue_d  = 4'h0;
    if (!video_on) begin
      red_d = 4'h0;
    end else if (plane_px) begin
      red_d = 4'hF;
    end else if (obs_px) begin
      red_d   = 4'hF;
      green_d = 4'hF;
    end else if (dash_px) begin
      red_d   = 4'hF;
      green_d = 4'hF;
      blue_d  = 4'hF;
    end else if (game_over_q) begin
      red_d = 4'h4;
    end
  end

  logic        left_req, right_req, restart_req;
  logic [11:0] scroll_sum, obs_next, obs_upd;

  always_comb begin
    player_lane_d  = player_lane_q;
    obs_lane_d     = obs_lane_q;
    obs_y_d        = obs_y_q;
    scroll_d       = scroll_q;
    score_d        = score_q;
    game_over_d    = game_over_q;
    lfsr_d         = {lfsr_q[6:0], ^(lfsr_q & 8'hB8)};
    // A request landing on the tick cycle itself still takes effect this frame.
    left_req       = left_pend_q | move_left;
    right_req      = right_pend_q | move_right;
    restart_req    = restart_pend_q | restart;
    left_pend_d    = frame_tick ? 1'b0 : left_req;
    right_pend_d   = frame_tick ? 1'b0 : right_req;
    restart_pend_d = frame_tick ? 1'b0 : restart_req;
    scroll_sum     = {2'b00, scroll_q} + STEP_C;
    obs_next       = {2'b00, obs_y_q} + OBS_SPEED_C;
    obs_upd        = 12'd0;

    if (frame_tick) begin
      if (restart_req) begin
        game_over_d   = 1'b0;
        score_d       = 8'd0;
        obs_y_d       = 10'd0;
        obs_lane_d    = 3'd0;
        player_lane_d = LANE_MID;
        scroll_d      = 10'd0;
      end else if (!game_over_q) begin
        if (left_req && !right_req && (player_lane_q != 3'd0)) begin
          player_lane_d = player_lane_q - 3'd1;
        end else if (right_req && !left_req && (player_lane_q != LANE_MAX)) begin
          player_lane_d = player_lane_q + 3'd1;
        end
        if (scroll_sum >= PERIOD_C) scroll_d = 10'(scroll_sum - PERIOD_C);
        else                        scroll_d = 10'(scroll_sum);
        if (obs_next >= V_ACTIVE_C) begin
          obs_y_d    = 10'd0;
          obs_lane_d = 3'(lfsr_q % LANE_CNT_C);
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end else begin
          obs_y_d = 10'(obs_next);
        end
        // Collision uses this frame's new positions.
        obs_upd = {2'b00, obs_y_d};
        if ((player_lane_d == obs_lane_d) && (obs_upd + OBS_SIZE_C > PLANE_Y_C) &&
            (obs_upd < PLANE_Y_C + PLANE_H_C)) begin
          game_over_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      player_lane_q  <= LANE_MID;
      obs_lane_q     <= 3'd0;
      obs_y_q        <= 10'd0;
      scroll_q       <= 10'd0;
      score_q        <= 8'd0;
      game_over_q    <= 1'b0;
      lfsr_q         <= 8'hA5;
      left_pend_q    <= 1'b0;
      right_pend_q   <= 1'b0;
      restart_pend_q <= 1'b0;
      red_q          <= 4'h0;
      green_q        <= 4'h0;
      blue_q         <= 4'h0;
    end else begin
      player_lane_q  <= player_lane_d;
      obs_lane_q     <= obs_lane_d;
      obs_y_q        <= obs_y_d;
      scroll_q       <= scroll_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
      lfsr_q         <= lfsr_d;
      left_pend_q    <= left_pend_d;
      right_pend_q   <= right_pend_d;
      restart_pend_q <= restart_pend_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign game_over = game_over_q;
  assign score     = score_q;

endmodule

// File: tb/tb_lane_game_pixel_gen.sv
// Directed bench for lane_game_pixel_gen: drives pixels and frame ticks,
// probes the registered colour and compares against hand-computed values.
module tb_lane_game_pixel_gen;

  logic       clk_d = 1'b0;
  logic       rst_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, move_left, move_right, restart;
  logic [3:0] red, green, blue;
  logic       game_over;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  logic [7:0] lfsr_model;
  int         exp_lane, other_lane, player, found;

  lane_game_pixel_gen dut (
    .clk_d(clk_d), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .move_left(move_left), .move_right(move_right),
    .restart(restart), .red(red), .green(green), .blue(blue),
    .game_over(game_over), .score(score)
  );

  always #5 clk_d = ~clk_d;

  // Free-running reference of the 8-bit LFSR (x^8+x^6+x^5+x^4+1), seeded at reset.
  always @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) lfsr_model <= 8'hA5;
    else        lfsr_model <= {lfsr_model[6:0], ^(lfsr_model & 8'hB8)};
  end

  function automatic logic [15:0] rgb();
    return {4'h0, red, green, blue};
  endfunction

  function automatic logic [9:0] laneCx(input int lane);
    return 10'(lane * 213 + 106);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic von);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    @(negedge clk_d);
  endtask

  task automatic tickFrames(input int n);
    pixel_x  = 10'd0;
    pixel_y  = 10'd480;
    video_on = 1'b0;
    repeat (n) @(negedge clk_d);
    pixel_y = 10'd0;
  endtask

  task automatic pulseRequest(input int which);
    if (which == 0) move_left = 1'b1;
    else if (which == 1) move_right = 1'b1;
    else restart = 1'b1;
    @(negedge clk_d);
    move_left  = 1'b0;
    move_right = 1'b0;
    restart    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0;
    move_left = 1'b0; move_right = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk_d);
    checkOutput("reset_rgb", rgb(), 16'h0000);
    checkOutput("reset_score", {8'h0, score}, 16'h0000);
    checkOutput("reset_gameover", {15'h0, game_over}, 16'h0000);
    rst_n = 1'b1;

    applyStimulus(10'd319, 10'd390, 1'b1); checkOutput("plane_lane1", rgb(), 16'h0F00);
    applyStimulus(10'd213, 10'd10, 1'b1);  checkOutput("dash_y10", rgb(), 16'h0FFF);
    applyStimulus(10'd213, 10'd80, 1'b1);  checkOutput("gap_y80", rgb(), 16'h0000);
    applyStimulus(10'd319, 10'd390, 1'b0); checkOutput("blank", rgb(), 16'h0000);

    tickFrames(5);
    applyStimulus(10'd213, 10'd65, 1'b1);  checkOutput("scroll10_y65", rgb(), 16'h0FFF);
    applyStimulus(10'd213, 10'd5, 1'b1);   checkOutput("scroll10_y5", rgb(), 16'h0000);
    tickFrames(55);
    applyStimulus(10'd213, 10'd0, 1'b1);   checkOutput("wrap_y0", rgb(), 16'h0FFF);
    applyStimulus(10'd213, 10'd70, 1'b1);  checkOutput("wrap_y70", rgb(), 16'h0000);

    pulseRequest(0); pulseRequest(0); tickFrames(1);
    applyStimulus(10'd106, 10'd390, 1'b1); checkOutput("plane_lane0", rgb(), 16'h0F00);
    applyStimulus(10'd319, 10'd390, 1'b1); checkOutput("lane1_empty", rgb(), 16'h0000);
    pulseRequest(0); pulseRequest(1); tickFrames(1);
    applyStimulus(10'd106, 10'd390, 1'b1); checkOutput("both_no_move", rgb(), 16'h0F00);
    pulseRequest(0); tickFrames(1);
    applyStimulus(10'd106, 10'd390, 1'b1); checkOutput("clamp_left", rgb(), 16'h0F00);

    tickFrames(22);
    checkOutput("no_hit_tick85", {15'h0, game_over}, 16'h0000);
    tickFrames(1);
    checkOutput("hit_tick86", {15'h0, game_over}, 16'h0001);
    applyStimulus(10'd500, 10'd100, 1'b1); checkOutput("gameover_bg", rgb(), 16'h0400);
    tickFrames(10);
    applyStimulus(10'd106, 10'd344, 1'b1); checkOutput("frozen_obs", rgb(), 16'h0FF0);
    applyStimulus(10'd106, 10'd343, 1'b1); checkOutput("frozen_obs_top", rgb(), 16'h0400);
    applyStimulus(10'd213, 10'd52, 1'b1);  checkOutput("frozen_dash", rgb(), 16'h0FFF);
    applyStimulus(10'd213, 10'd51, 1'b1);  checkOutput("frozen_gap", rgb(), 16'h0400);
    checkOutput("frozen_score", {8'h0, score}, 16'h0000);

    pulseRequest(2); tickFrames(1);
    checkOutput("restart_gameover", {15'h0, game_over}, 16'h0000);
    checkOutput("restart_score", {8'h0, score}, 16'h0000);
    applyStimulus(10'd319, 10'd390, 1'b1); checkOutput("restart_lane1", rgb(), 16'h0F00);
    applyStimulus(10'd106, 10'd10, 1'b1);  checkOutput("restart_obs", rgb(), 16'h0FF0);
    applyStimulus(10'd213, 10'd70, 1'b1);  checkOutput("restart_scroll", rgb(), 16'h0000);
    applyStimulus(10'd500, 10'd100, 1'b1); checkOutput("restart_bg", rgb(), 16'h0000);

    pulseRequest(1); tickFrames(1); tickFrames(118);
    exp_lane = int'(lfsr_model % 8'd3);
    tickFrames(1);
    checkOutput("respawn_score", {8'h0, score}, 16'h0001);
    applyStimulus(laneCx(exp_lane), 10'd10, 1'b1); checkOutput("respawn_lane", rgb(), 16'h0FF0);
    other_lane = (exp_lane + 1) % 3;
    applyStimulus(laneCx(other_lane), 10'd10, 1'b1); checkOutput("respawn_other", rgb(), 16'h0000);
    applyStimulus(10'd532, 10'd390, 1'b1); checkOutput("plane_lane2", rgb(), 16'h0F00);

    // Dodge every obstacle until the score saturates.
    player = 2;
    for (int r = 0; r < 255; r++) begin
      found = 3;
      for (int l = 0; l < 3; l++) begin
        applyStimulus(laneCx(l), 10'd10, 1'b1);
        if (rgb() == 16'h0FF0) found = l;
      end
      if (found == player) begin
        if (player == 0) begin pulseRequest(1); player = 1; end
        else begin pulseRequest(0); player = player - 1; end
      end
      tickFrames(120);
      if (r == 253) checkOutput("score_255", {8'h0, score}, 16'h00FF);
    end
    checkOutput("score_saturated", {8'h0, score}, 16'h00FF);
    checkOutput("dodge_no_hit", {15'h0, game_over}, 16'h0000);

    applyStimulus(laneCx(player), 10'd390, 1'b1);
    checkOutput("pre_reset_plane", rgb(), 16'h0F00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rgb", rgb(), 16'h0000);
    checkOutput("async_reset_score", {8'h0, score}, 16'h0000);
    @(negedge clk_d);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
